// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Contents:
//   fetch_entry_t     - one queued fetch: {pc, inst, misaligned}
//   INST_BYTES        - PC increment per fetched instruction
//   DEFAULT_RESET_PC  - default PC loaded on reset
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch entries between the PC stage and decode.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push, wr_entry    - enqueue wr_entry (ignored when full without a pop)
//   pop               - dequeue the head (ignored when empty)
//   flush             - drop all entries; overrides push and pop
//   head              - entry at the read pointer, straight from storage
//   full, empty       - occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection and the
// valid/ready handshake to decode, with a small fetch queue in between.
// Configuration macro: FETCH_MISALIGN_CHECK_EN
//   defined   - redirect target loaded as-is, entries from PC[1:0]!=0 flagged
//   undefined - redirect target word-aligned, o_misaligned always 0
// Ports:
//   i_clk, i_reset          - clock, asynchronous active-high reset
//   o_addr_inst, i_inst     - instruction memory address (= PC) and word
//   i_redirect, i_redirect_pc - flush and restart fetch at the target
//   o_valid, o_inst, o_pc, o_misaligned - queue head to decode
//   i_ready                 - decode accepts the head this cycle
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_addr_inst,
    input  logic [31:0] i_inst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_misaligned,
    input  logic        i_ready
);

    logic [31:0]  pc;
    logic [31:0]  pc_next_c;
    logic [31:0]  redirect_target_c;
    logic         entry_misaligned_c;
    logic         push_c;
    logic         pop_c;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_target_c  = i_redirect_pc;
    assign entry_misaligned_c = |pc[1:0];
`else
    assign redirect_target_c  = {i_redirect_pc[31:2], 2'b00};
    assign entry_misaligned_c = 1'b0;
`endif

    // A full queue can still accept a fetch when decode drains the head.
    assign pop_c  = !empty && i_ready;
    assign push_c = !full || pop_c;

    assign wr_entry = '{pc: pc, inst: i_inst, misaligned: entry_misaligned_c};

    // Redirect wins over sequential fetch; PC wraps modulo 2^32.
    always_comb begin
        pc_next_c = pc;
        if (i_redirect) begin
            pc_next_c = redirect_target_c;
        end else if (push_c) begin
            pc_next_c = pc + 32'(INST_BYTES);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (i_clk),
        .rst      (i_reset),
        .push     (push_c),
        .wr_entry (wr_entry),
        .pop      (pop_c),
        .flush    (i_redirect),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign o_addr_inst  = pc;
    assign o_valid      = !empty;
    assign o_inst       = head.inst;
    assign o_pc         = head.pc;
    assign o_misaligned = head.misaligned;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, free-run, backpressure, redirect,
// redirect under backpressure, PC wrap-around, misaligned redirect and
// asynchronous reset. A second instance starts near the top of the address
// space to exercise PC wrap.
module tb_if_fetch_unit;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] o_addr_inst;
    logic [31:0] i_inst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_misaligned;
    logic        i_ready;

    logic [31:0] w_addr_inst;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [31:0] w_o_inst;
    logic [31:0] w_pc;
    logic        w_misaligned;

    int checks;
    int errors;

    // Instruction memory: word i holds 32'h1000_0000 + i.
    assign i_inst = 32'h1000_0000 + {2'b00, o_addr_inst[31:2]};
    assign w_inst = 32'h1000_0000 + {2'b00, w_addr_inst[31:2]};

    if_fetch_unit dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_addr_inst   (o_addr_inst),
        .i_inst        (i_inst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_misaligned  (o_misaligned),
        .i_ready       (i_ready)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_addr_inst   (w_addr_inst),
        .i_inst        (w_inst),
        .i_redirect    (1'b0),
        .i_redirect_pc (32'h0000_0000),
        .o_valid       (w_valid),
        .o_inst        (w_o_inst),
        .o_pc          (w_pc),
        .o_misaligned  (w_misaligned),
        .i_ready       (1'b1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Synchronous-looking reset pulse; leaves the bench in the first cycle after release.
    task automatic do_reset(input logic rdy);
        i_reset    = 1'b1;
        i_redirect = 1'b0;
        i_ready    = rdy;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_ready       = 1'b0;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b exp 0", o_valid);
        end
        checks++;
        if (o_inst !== 32'h0 || o_pc !== 32'h0 || o_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_head got inst %h pc %h mis %0b exp 0 0 0", o_inst, o_pc, o_misaligned);
        end
        checks++;
        if (o_addr_inst !== 32'h0) begin
            errors++; $display("FAIL reset_addr got %h exp 00000000", o_addr_inst);
        end
        checks++;
        if (w_addr_inst !== 32'hFFFF_FFF8 || w_valid !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got addr %h valid %0b exp fffffff8 0", w_addr_inst, w_valid);
        end
    endtask

    // Continues straight out of test_reset with decode always ready.
    task automatic test_free_run();
        logic [31:0] exp_w_pc;
        i_ready = 1'b1;
        i_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_inst !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL free_run[%0d] got v %0b pc %h inst %h exp 1 %h %h",
                         k, o_valid, o_pc, o_inst, 32'(4 * k), 32'h1000_0000 + 32'(k));
            end
            if (k < 3) begin
                exp_w_pc = 32'hFFFF_FFF8 + 32'(4 * k);
                checks++;
                if (w_valid !== 1'b1 || w_pc !== exp_w_pc ||
                    w_o_inst !== 32'h1000_0000 + {2'b00, exp_w_pc[31:2]}) begin
                    errors++;
                    $display("FAIL wrap[%0d] got v %0b pc %h inst %h exp pc %h",
                             k, w_valid, w_pc, w_o_inst, exp_w_pc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
            errors++; $display("FAIL bp_first got v %0b pc %h exp 1 0", o_valid, o_pc);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++;
            if (o_addr_inst !== 32'h8 || o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== 32'h1000_0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] got addr %h v %0b pc %h inst %h exp 8 1 0 10000000",
                         k, o_addr_inst, o_valid, o_pc, o_inst);
            end
        end
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_inst !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL bp_release[%0d] got v %0b pc %h inst %h exp 1 %h",
                         k, o_valid, o_pc, o_inst, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h10) begin
            errors++; $display("FAIL redir_pre got v %0b pc %h exp 1 10", o_valid, o_pc);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_addr_inst !== 32'h40) begin
            errors++; $display("FAIL redir_bubble got v %0b addr %h exp 0 40", o_valid, o_addr_inst);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_inst !== 32'h1000_0010) begin
            errors++; $display("FAIL redir_target got v %0b pc %h inst %h exp 1 40 10000010", o_valid, o_pc, o_inst);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h44 || o_inst !== 32'h1000_0011) begin
            errors++; $display("FAIL redir_next got v %0b pc %h inst %h exp 1 44 10000011", o_valid, o_pc, o_inst);
        end
    endtask

    task automatic test_redirect_backpressure();
        do_reset(1'b0);
        tick();
        tick();
        checks++;
        if (o_addr_inst !== 32'h8 || o_pc !== 32'h0) begin
            errors++; $display("FAIL rbp_full got addr %h pc %h exp 8 0", o_addr_inst, o_pc);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_addr_inst !== 32'h100) begin
            errors++; $display("FAIL rbp_flush got v %0b addr %h exp 0 100", o_valid, o_addr_inst);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== 32'h1000_0040 || o_addr_inst !== 32'h104) begin
            errors++;
            $display("FAIL rbp_target got v %0b pc %h inst %h addr %h exp 1 100 10000040 104",
                     o_valid, o_pc, o_inst, o_addr_inst);
        end
        tick();
        checks++;
        if (o_pc !== 32'h100 || o_addr_inst !== 32'h108) begin
            errors++; $display("FAIL rbp_hold got pc %h addr %h exp 100 108", o_pc, o_addr_inst);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
        logic        exp_mis;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_pc0 = 32'h22;
        exp_pc1 = 32'h26;
        exp_mis = 1'b1;
`else
        exp_pc0 = 32'h20;
        exp_pc1 = 32'h24;
        exp_mis = 1'b0;
`endif
        i_ready       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h22;
        tick();
        i_redirect = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== exp_pc0 || o_misaligned !== exp_mis || o_inst !== 32'h1000_0008) begin
            errors++;
            $display("FAIL misalign_first got v %0b pc %h mis %0b inst %h exp 1 %h %0b 10000008",
                     o_valid, o_pc, o_misaligned, o_inst, exp_pc0, exp_mis);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== exp_pc1 || o_misaligned !== exp_mis || o_inst !== 32'h1000_0009) begin
            errors++;
            $display("FAIL misalign_next got v %0b pc %h mis %0b inst %h exp 1 %h %0b 10000009",
                     o_valid, o_pc, o_misaligned, o_inst, exp_pc1, exp_mis);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h8) begin
            errors++; $display("FAIL areset_pre got v %0b pc %h exp 1 8", o_valid, o_pc);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_inst !== 32'h0 || o_addr_inst !== 32'h0) begin
            errors++;
            $display("FAIL areset_now got v %0b pc %h inst %h addr %h exp 0 0 0 0",
                     o_valid, o_pc, o_inst, o_addr_inst);
        end
        checks++;
        if (w_valid !== 1'b0 || w_addr_inst !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL areset_wrap got v %0b addr %h exp 0 fffffff8", w_valid, w_addr_inst);
        end
        tick();
        i_reset = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== 32'h1000_0000) begin
            errors++; $display("FAIL areset_restart got v %0b pc %h inst %h exp 1 0 10000000", o_valid, o_pc, o_inst);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_redirect_backpressure();
        test_misalign();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
